// File: rtl/seq_div_8.sv
// seq_div_8: iterative restoring unsigned divider with valid/ready request and response ports
// Ports: clk, rst (async, active-high); in_valid/in_ready with dividend/divisor sampled on accept;
//        out_valid/out_ready with quotient/remainder/div_by_zero; busy high while CALC or DONE.
module seq_div_8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] a, r, d, a_nx, r_nx, t;
    logic [WIDTH:0] rs;
    logic [CW-1:0] count;
    logic c_low, carry, accept, last, handoff;
    always_comb begin
        rs = {r, a[WIDTH-1]};
        // A set top bit of rs already exceeds any divisor, so only the low bits need the trial subtract
        {c_low, t} = {1'b0, rs[WIDTH-1:0]} + {1'b0, ~d} + {{WIDTH{1'b0}}, 1'b1};
        carry = rs[WIDTH] | c_low;
        a_nx = {a[WIDTH-2:0], carry};
        r_nx = carry ? t : rs[WIDTH-1:0];
        in_ready = state == IDLE;
        busy = state != IDLE;
        accept = in_valid & in_ready;
        last = count == CW'(WIDTH - 1);
        handoff = out_valid & out_ready;
        state_nx = state;
        case (state)
            IDLE: state_nx = accept ? (divisor == '0 ? DONE : CALC) : IDLE;
            CALC: state_nx = last ? DONE : CALC;
            DONE: state_nx = handoff ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            a <= '0;
            r <= '0;
            d <= '0;
            quotient <= '0;
            remainder <= '0;
            div_by_zero <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state <= state_nx;
            // Result is published one edge after entering DONE
            out_valid <= state == DONE && !handoff;
            if (accept) begin
                d <= divisor;
                a <= dividend;
                r <= '0;
                count <= '0;
                div_by_zero <= divisor == '0;
                if (divisor == '0) begin
                    quotient <= '1;
                    remainder <= dividend;
                end
            end else if (state == CALC) begin
                a <= a_nx;
                r <= r_nx;
                count <= count + 1'b1;
                if (last) begin
                    quotient <= a_nx;
                    remainder <= r_nx;
                end
            end
        end
    end
endmodule
